bus_reply_unit: RTL and testbench

Bus slave-side responder for the 1801VM1 soft CPU. It sits directly downstream of the CPU's bus sequencer, samples SYNC/DIN/DOUT/WTBT and the address, decodes the target region, and generates memory strobes, byte-lane write enables and the RPLY handshake back to the CPU. It also runs a bus timeout and raises a one-cycle error pulse for the CPU error input when no slave answers.

---
 rtl/bus_reply_unit_pkg.sv | 38 +++
 rtl/bus_addr_decode.sv | 23 ++
 rtl/bus_reply_unit.sv | 143 ++++++++++++++
 tb/tb_bus_reply_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_reply_unit_pkg.sv
// Shared types and constants for the 1801VM1 bus reply unit: state and region-class
// encodings, address-map limits and the byte-lane helper.
package bus_reply_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_IOWAIT = 3'd2,
    ST_REPLY  = 3'd3,
    ST_ERROR  = 3'd4,
    ST_HOLD   = 3'd5
  } state_e;

  // One-hot so each select output is a single bit of the latched class.
  typedef enum logic [2:0] {
    CLS_NONE = 3'b000,
    CLS_RAM  = 3'b001,
    CLS_ROM  = 3'b010,
    CLS_IO   = 3'b100
  } cls_e;

  typedef struct packed {
    logic lo;
    logic hi;
  } lanes_t;

  localparam logic [15:0] RAM_TOP = 16'o077777;
  localparam logic [15:0] IO_BASE = 16'o177000;
  localparam int          CNT_W   = 8;

  function automatic lanes_t byte_lanes(input logic wtbt, input logic a0);
    lanes_t l;
    l.lo = !wtbt || !a0;
    l.hi = !wtbt || a0;
    return l;
  endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational region classifier and byte-lane decoder; zero latency, no flow control.
// Interrupt-acknowledge reads are always steered to the I/O class.
module bus_addr_decode
  import bus_reply_unit_pkg::*;
(
  input  logic [15:0] addr,
  input  logic        iako,
  input  logic        wtbt,
  output cls_e        cls,
  output lanes_t      lanes
);

  always_comb begin
    cls = CLS_RAM;
    if (iako || (addr >= IO_BASE)) begin
      cls = CLS_IO;
    end else if (addr > RAM_TOP) begin
      cls = CLS_ROM;
    end
    lanes = byte_lanes(wtbt, addr[0]);
  end

endmodule

// File: rtl/bus_reply_unit.sv
// Bus slave responder: decodes region, drives strobes and RPLY (RAM/ROM: WAIT+2 ce-cycles,
// I/O: 1 ce-cycle after io_ack), times out silent I/O with an error pulse; stalls on ce=0.
module bus_reply_unit
  import bus_reply_unit_pkg::*;
#(
  parameter int RAM_WAIT = 1,
  parameter int ROM_WAIT = 2,
  parameter int TIMEOUT  = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        SYNC,
  input  logic        DIN,
  input  logic        DOUT,
  input  logic        WTBT,
  input  logic        IAKO,
  input  logic [15:0] addr_i,
  input  logic        io_ack,
  output logic        RPLY,
  output logic        error_o,
  output logic        ram_sel,
  output logic        rom_sel,
  output logic        io_sel,
  output logic        rd,
  output logic        we_lo,
  output logic        we_hi,
  output logic        busy
);

  localparam logic [CNT_W-1:0] RAM_LOAD = CNT_W'(RAM_WAIT);
  localparam logic [CNT_W-1:0] ROM_LOAD = CNT_W'(ROM_WAIT);
  // IOWAIT occupies TIMEOUT ce-cycles before ERROR is entered.
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d;
  lanes_t           lanes_q, lanes_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync_q, sync_d;

  cls_e             dec_cls;
  lanes_t           dec_lanes;
  logic             xfer;

  bus_addr_decode u_decode (
    .addr  (addr_i),
    .iako  (IAKO),
    .wtbt  (WTBT),
    .cls   (dec_cls),
    .lanes (dec_lanes)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cls_q   <= CLS_NONE;
      lanes_q <= '0;
      cnt_q   <= '0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      lanes_q <= lanes_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    lanes_d = lanes_q;
    cnt_d   = cnt_q;
    sync_d  = sync_q;
    if (ce) begin
      sync_d = SYNC;
      case (state_q)
        ST_IDLE: begin
          if (SYNC && !sync_q) begin
            cls_d   = dec_cls;
            lanes_d = dec_lanes;
            if (dec_cls == CLS_IO) begin
              state_d = ST_IOWAIT;
              cnt_d   = TMO_LOAD;
            end else begin
              state_d = ST_WAIT;
              cnt_d   = (dec_cls == CLS_ROM) ? ROM_LOAD : RAM_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (!SYNC) begin
            state_d = ST_IDLE;
          end else if (cnt_q == '0) begin
            state_d = ST_REPLY;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_IOWAIT: begin
          // io_ack outranks expiry when both land on the same ce cycle.
          if (!SYNC) begin
            state_d = ST_IDLE;
          end else if (io_ack) begin
            state_d = ST_REPLY;
          end else if (cnt_q == '0) begin
            state_d = ST_ERROR;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_REPLY: begin
          if (!SYNC) state_d = ST_IDLE;
        end
        ST_ERROR: begin
          state_d = ST_HOLD;
        end
        ST_HOLD: begin
          if (!SYNC) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    busy    = (state_q != ST_IDLE);
    xfer    = (state_q == ST_WAIT) || (state_q == ST_IOWAIT) || (state_q == ST_REPLY);
    RPLY    = (state_q == ST_REPLY);
    error_o = (state_q == ST_ERROR);
    ram_sel = busy && cls_q[0];
    rom_sel = busy && cls_q[1];
    io_sel  = busy && cls_q[2];
    rd      = xfer && DIN;
    // ROM writes still get a reply but never reach the array.
    we_lo   = xfer && DOUT && lanes_q.lo && !cls_q[1];
    we_hi   = xfer && DOUT && lanes_q.hi && !cls_q[1];
  end

endmodule

// File: tb/tb_bus_reply_unit.sv
// Directed bench for bus_reply_unit with default parameters (RAM_WAIT=1, ROM_WAIT=2, TIMEOUT=63).
// Latencies are counted in clk edges from the edge that first samples SYNC high (that edge counts as 1).
module tb_bus_reply_unit;

  logic        clk = 1'b0;
  logic        reset, ce, SYNC, DIN, DOUT, WTBT, IAKO, io_ack;
  logic [15:0] addr_i;
  logic        RPLY, error_o, ram_sel, rom_sel, io_sel, rd, we_lo, we_hi, busy;

  int nchk = 0;
  int nerr = 0;
  int n;
  logic seen;

  always #5 clk = ~clk;

  bus_reply_unit dut (
    .clk     (clk),
    .reset   (reset),
    .ce      (ce),
    .SYNC    (SYNC),
    .DIN     (DIN),
    .DOUT    (DOUT),
    .WTBT    (WTBT),
    .IAKO    (IAKO),
    .addr_i  (addr_i),
    .io_ack  (io_ack),
    .RPLY    (RPLY),
    .error_o (error_o),
    .ram_sel (ram_sel),
    .rom_sel (rom_sel),
    .io_sel  (io_sel),
    .rd      (rd),
    .we_lo   (we_lo),
    .we_hi   (we_hi),
    .busy    (busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] outs();
    return {RPLY, error_o, ram_sel, rom_sel, io_sel, rd, we_lo, we_hi, busy};
  endfunction

  task automatic start(input logic [15:0] a, input logic din, input logic dout,
                       input logic wtbt, input logic iako);
    addr_i = a;
    DIN    = din;
    DOUT   = dout;
    WTBT   = wtbt;
    IAKO   = iako;
    SYNC   = 1'b1;
  endtask

  task automatic finish_xfer(input string tag);
    SYNC = 1'b0;
    DIN  = 1'b0;
    DOUT = 1'b0;
    WTBT = 1'b0;
    IAKO = 1'b0;
    tick();
    check(tag, {RPLY, busy}, 2'b00);
    tick();
  endtask

  task automatic wait_rply(input int maxc, output int cnt);
    cnt = -1;
    for (int i = 1; i <= maxc; i++) begin
      tick();
      if (RPLY) begin
        cnt = i;
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b1; ce = 1'b1; SYNC = 1'b0; DIN = 1'b0; DOUT = 1'b0;
    WTBT = 1'b0; IAKO = 1'b0; io_ack = 1'b0; addr_i = '0;
    tick();
    tick();
    check("reset_outs", outs(), 9'd0);
    reset = 1'b0;
    tick();
    check("idle_outs", outs(), 9'd0);

    // RAM word write: 1 + RAM_WAIT + 1 edges
    start(16'o001000, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_rply(20, n);
    check("ram_wr_lat", n, 3);
    check("ram_wr_sel", {ram_sel, rom_sel, io_sel}, 3'b100);
    check("ram_wr_strb", {rd, we_lo, we_hi}, 3'b011);
    finish_xfer("ram_wr_fall");

    start(16'o001001, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_rply(20, n);
    check("byte_hi_lat", n, 3);
    check("byte_hi_we", {we_lo, we_hi}, 2'b01);
    finish_xfer("byte_hi_fall");

    start(16'o001000, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_rply(20, n);
    check("byte_lo_we", {we_lo, we_hi}, 2'b10);
    finish_xfer("byte_lo_fall");

    // ROM read: 1 + ROM_WAIT + 1 edges
    start(16'o100000, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("rom_rd_strb", {rom_sel, rd, RPLY}, 3'b110);
    wait_rply(20, n);
    check("rom_rd_lat", n + 1, 4);
    check("rom_rd_sel", {ram_sel, rom_sel, io_sel}, 3'b010);
    finish_xfer("rom_rd_fall");

    start(16'o100000, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_rply(20, n);
    check("rom_wr_lat", n, 4);
    check("rom_wr_we", {we_lo, we_hi}, 2'b00);
    finish_xfer("rom_wr_fall");

    // I/O read answered by io_ack after 5 cycles
    start(16'o177716, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) tick();
    check("io_wait", {RPLY, io_sel, rd, busy}, 4'b0111);
    io_ack = 1'b1;
    tick();
    check("io_rply", {RPLY, error_o}, 2'b10);
    io_ack = 1'b0;
    finish_xfer("io_fall");

    // Vector read at address 0 must go to I/O, not RAM
    start(16'o000000, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (2) tick();
    check("vec_sel", {ram_sel, rom_sel, io_sel, RPLY}, 4'b0010);
    io_ack = 1'b1;
    tick();
    check("vec_rply", RPLY, 1'b1);
    io_ack = 1'b0;
    finish_xfer("vec_fall");

    // Silent I/O: error enters TIMEOUT edges after the sampling edge -> observed on edge 64
    start(16'o177000, 1'b1, 1'b0, 1'b0, 1'b0);
    n = -1;
    seen = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (RPLY) seen = 1'b1;
      if (error_o) begin
        n = i;
        break;
      end
    end
    check("tmo_lat", n, 64);
    check("tmo_norply", seen, 1'b0);
    tick();
    check("tmo_once", {error_o, RPLY, busy}, 3'b001);
    repeat (3) tick();
    check("tmo_hold", {error_o, RPLY, busy}, 3'b001);
    finish_xfer("tmo_idle");

    // io_ack on the expiry cycle wins
    start(16'o177000, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (63) tick();
    check("race_pre", {RPLY, error_o, busy}, 3'b001);
    io_ack = 1'b1;
    tick();
    check("race_rply", {RPLY, error_o}, 2'b10);
    io_ack = 1'b0;
    finish_xfer("race_fall");

    // Abort in WAIT
    start(16'o002000, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    SYNC = 1'b0;
    DIN  = 1'b0;
    tick();
    check("abort_idle", {RPLY, busy}, 2'b00);
    repeat (4) tick();
    check("abort_quiet", {RPLY, error_o, busy}, 3'b000);

    // Reset while replying
    start(16'o001000, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_rply(20, n);
    check("rst_pre", RPLY, 1'b1);
    reset = 1'b1;
    tick();
    check("rst_outs", outs(), 9'd0);
    SYNC  = 1'b0;
    DOUT  = 1'b0;
    reset = 1'b0;
    tick();

    // ce low for 10 clk mid-WAIT stretches latency by exactly 10
    start(16'o001000, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    ce = 1'b0;
    repeat (10) tick();
    check("ce_hold", {RPLY, ram_sel, we_lo, we_hi, busy}, 5'b01111);
    ce = 1'b1;
    wait_rply(30, n);
    check("ce_lat", n + 12, 13);
    finish_xfer("ce_fall");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
